// File: rtl/iterative_divider.sv
// Sequential signed restoring divider: 2N-bit dividend / N-bit divisor -> N-bit
// quotient and remainder, one quotient bit per clock, start/busy/done handshake.
module iterative_divider #(
  parameter int N = 32
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [2*N-1:0] dividend_i,
  input  logic [N-1:0]   divisor_i,
  output logic [N-1:0]   quotient_o,
  output logic [N-1:0]   remainder_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           overflow_o,
  output logic           div_by_zero_o
);

  localparam int CW = $clog2(2*N+1);
  // Largest quotient magnitudes that still fit in N signed bits.
  localparam logic [2*N-1:0] POS_LIM = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [2*N-1:0] NEG_LIM = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e         state_q, state_d;
  logic [2*N-1:0] dvd_q, dvd_d;   // dividend bits leave at the MSB, quotient bits enter at the LSB
  logic [N-1:0]   rem_q, rem_d;
  logic [N-1:0]   dsr_q, dsr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic           zero_q, zero_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   rmd_q, rmd_d;
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;
  logic           dz_q, dz_d;

  logic [N:0]     trial;
  logic [N:0]     diff;
  logic           ge;
  logic [2*N-1:0] abs_dvd;
  logic [N-1:0]   abs_dsr;
  logic [2*N-1:0] quo_signed;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    done_d    = 1'b0;

    trial      = {rem_q, dvd_q[2*N-1]};
    diff       = trial - {1'b0, dsr_q};
    ge         = ~diff[N];
    abs_dvd    = dividend_i[2*N-1] ? -dividend_i : dividend_i;
    abs_dsr    = divisor_i[N-1] ? -divisor_i : divisor_i;
    quo_signed = neg_quo_q ? -dvd_q : dvd_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          neg_quo_d = dividend_i[2*N-1] ^ divisor_i[N-1];
          neg_rem_d = dividend_i[2*N-1];
          rem_d     = '0;
          dsr_d     = abs_dsr;
          cnt_d     = CW'(2*N);
          if (divisor_i == '0) begin
            // Raw dividend is kept so its low half can be returned as the remainder.
            zero_d  = 1'b1;
            dvd_d   = dividend_i;
            state_d = FIX;
          end else begin
            zero_d  = 1'b0;
            dvd_d   = abs_dvd;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = ge ? diff[N-1:0] : trial[N-1:0];
        dvd_d = {dvd_q[2*N-2:0], ge};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (zero_q) begin
          quo_d = '1;
          rmd_d = dvd_q[N-1:0];
          ovf_d = 1'b0;
          dz_d  = 1'b1;
        end else begin
          quo_d = quo_signed[N-1:0];
          rmd_d = neg_rem_q ? -rem_q : rem_q;
          ovf_d = neg_quo_q ? (dvd_q > NEG_LIM) : (dvd_q > POS_LIM);
          dz_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      quo_q     <= '0;
      rmd_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      dsr_q     <= dsr_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      quo_q     <= quo_d;
      rmd_q     <= rmd_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
    end
  end

  assign quotient_o    = quo_q;
  assign remainder_o   = rmd_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign overflow_o    = ovf_q;
  assign div_by_zero_o = dz_q;

endmodule

// File: doc/iterative_divider.md
# iterative_divider

Sequential signed divider that inverts the team's registered signed multiplier: it takes a 2N-bit signed dividend, such as a full product, and an N-bit signed divisor. It produces an N-bit quotient and an N-bit remainder using restoring division, one quotient bit per clock. It sits beside the multiplier in the arithmetic datapath and uses a start/busy/done handshake, so callers can issue one operation at a time.

## Interface
- N, default 32, operand width; dividend is 2N bits, and divisor, quotient and remainder are N bits each
- clk  input  1  sole clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- start  input  1  request; sampled only in IDLE
- dividend  input  2N  signed dividend; sampled on the accepting edge only
- divisor  input  N  signed divisor; sampled on the accepting edge only
- quotient  output  N  signed quotient, truncated toward zero
- remainder  output  N  signed remainder, same sign as dividend (or zero)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; results valid
- overflow  output  1  quotient not representable in N signed bits
- div_by_zero  output  1  divisor was zero

## Operation
- States:
  - IDLE: start=1 → latch |dividend| (2N-bit unsigned), |divisor|, sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend).
    - Divisor ≠ 0 → CALC, iteration counter = 2N.
    - Divisor = 0 → FIX with zero flag set.
  - CALC:
    - Shift the partial remainder (N+1 bits) left and bring in the next dividend bit, MSB first.
    - Trial-subtract |divisor|. If non-negative, keep the difference and the quotient bit is 1; otherwise restore and the bit is 0.
    - Decrement the counter; counter reaches 0 → FIX.
  - FIX: register the outputs, pulse done, go to IDLE.
- Output rules applied in FIX:
  - Signed magnitudes: magnitude quotient is 2N bits; quotient = sign_q ? −mag : mag, low N bits driven; remainder = sign_r ? −rem : rem.
  - Overflow: overflow=1 iff the signed true quotient lies outside [−2^(N−1), 2^(N−1)−1]. Quotient output is then the low N bits of the true quotient; remainder is still exact.
  - Divide by zero: quotient = all ones, remainder = dividend[N−1:0], div_by_zero=1, overflow=0.
- |dividend| for dividend = −2^(2N−1) is 2^(2N−1); the 2N-bit unsigned register holds it exactly.
- start during busy is ignored (not queued).
- quotient, remainder, overflow and div_by_zero hold their values until the next FIX. They change only on the FIX edge.
- Inputs need only be stable on the accepting edge.

## Timing
- Reset (asynchronous, active-low): state IDLE; quotient=0, remainder=0, busy=0, done=0, overflow=0, div_by_zero=0.
  - Takes effect mid-operation with no partial result and no done pulse.
  - Release is not a start; a new start is needed.
- Accepting edge = E0:
  - busy=1 from after E0.
  - Normal operation: edges E1..E2N perform the iterations; E2N+1 is FIX.
  - After E2N+1: done=1 and results valid for one cycle; busy=0.
- Latency: 2N+1 cycles from the accepting edge to done (65 at N=32).
- Divide by zero: FIX at E1; done after E1 (latency 1).
- Back-to-back operation:
  - start may be high in the done cycle and is accepted.
  - The next done comes 2N+1 cycles later.
  - Throughput: one operation per 2N+1 cycles.
- done and busy are never both 1.

## Test plan
- N=32, dividend=100, divisor=7, start one cycle → busy 65 cycles; then done=1 for one cycle with quotient=14, remainder=2, overflow=0, div_by_zero=0.
- Sign combinations:
  - −100/7 → q=−14, r=−2.
  - 100/−7 → q=−14, r=2.
  - −100/−7 → q=14, r=−2.
  - 0/−5 → q=0, r=0.
- Overflow:
  - dividend=2^40, divisor=2 → overflow=1, quotient=0 (low 32 bits of 2^39), remainder=0.
  - dividend=−2^31, divisor=−1 → overflow=1, quotient=0x8000_0000.
  - dividend=−2^31, divisor=1 → overflow=0, q=−2^31.
- Divide by zero: dividend=5, divisor=0 → done one cycle after accept; quotient=0xFFFF_FFFF, remainder=5, div_by_zero=1; the next op clears the flag.
- Handshake:
  - start pulsed during busy is ignored; outputs unchanged until the original done.
  - start asserted in the done cycle starts a second op; its done arrives 65 cycles later with correct results.
- Reset: reset driven low at iteration 30 → all outputs 0 immediately, no done. After release, start 100/7 → correct result after 65 cycles.
